// File: rtl/ps2_host_ctrl.sv
// PS/2 keyboard host sequencer: reset/self-test/LED bring-up with retries, LED tracking
// while ready, and removal of protocol replies from the scancode stream.
module ps2_host_ctrl #(
  parameter int CLK_FREQ       = 28000000,
  parameter int ACK_TIMEOUT_MS = 20,
  parameter int BAT_TIMEOUT_MS = 1000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_req,
  input  logic       led_caps,
  input  logic       led_num,
  input  logic       led_scroll,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       tx_err,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] key_byte,
  output logic       key_valid,
  output logic       kbd_ready,
  output logic       kbd_error,
  output logic [3:0] dbg_state
);
  typedef enum logic [3:0] {
    RST_TX      = 4'd0,
    RST_ACK     = 4'd1,
    BAT_WAIT    = 4'd2,
    LED_CMD_TX  = 4'd3,
    LED_CMD_ACK = 4'd4,
    LED_DAT_TX  = 4'd5,
    LED_DAT_ACK = 4'd6,
    READY       = 4'd7,
    FAIL        = 4'd8
  } state_t;

  localparam logic [31:0] PRE_MAX    = 32'(CLK_FREQ / 1000 - 1);
  localparam logic [10:0] ACK_LIM    = 11'(ACK_TIMEOUT_MS);
  localparam logic [10:0] BAT_LIM    = 11'(BAT_TIMEOUT_MS);
  localparam logic [3:0]  RETRY_LAST = 4'(MAX_RETRY - 1);

  state_t      r_state;
  logic [31:0] r_pre;
  logic [10:0] r_ms;
  logic [3:0]  r_retry;
  logic [2:0]  r_led_shadow;
  logic [2:0]  r_led_live;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic [7:0]  r_key_byte;
  logic        r_key_valid;
  logic        r_kbd_ready;
  logic        r_kbd_error;

  logic        w_tick;
  logic        w_timeout;
  logic        w_in_ack;
  logic        w_ack_ok;
  logic        w_ack_fail;
  logic        w_bat_ok;
  logic        w_bat_fail;
  logic        w_fail;
  logic        w_is_scan;
  logic [2:0]  w_led_pins;
  state_t      w_retry_to;

  assign w_led_pins = {led_caps, led_num, led_scroll};
  assign w_tick     = (r_pre == PRE_MAX);
  assign w_timeout  = r_ms >= ((r_state == BAT_WAIT) ? BAT_LIM : ACK_LIM);
  assign w_in_ack   = (r_state == RST_ACK) || (r_state == LED_CMD_ACK) || (r_state == LED_DAT_ACK);

  // A reply byte in the same cycle as a timeout takes precedence over the timeout.
  assign w_ack_ok   = rx_valid && (rx_byte == 8'hFA);
  assign w_ack_fail = !w_ack_ok && ((rx_valid && (rx_byte == 8'hFE)) || tx_err || rx_err ||
                                    (w_timeout && !rx_valid));
  assign w_bat_ok   = rx_valid && (rx_byte == 8'hAA);
  assign w_bat_fail = !w_bat_ok && ((rx_valid && ((rx_byte == 8'hFC) || (rx_byte == 8'hFD))) ||
                                    rx_err || (w_timeout && !rx_valid));
  assign w_fail     = (w_in_ack && w_ack_fail) || ((r_state == BAT_WAIT) && w_bat_fail);
  assign w_retry_to = ((r_state == RST_ACK) || (r_state == BAT_WAIT)) ? RST_TX : LED_CMD_TX;
  assign w_is_scan  = !(rx_byte inside {8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RST_TX;
      r_ms         <= '0;
      r_retry      <= '0;
      r_led_shadow <= '0;
      r_led_live   <= '0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_key_byte   <= '0;
      r_key_valid  <= 1'b0;
      r_kbd_ready  <= 1'b0;
      r_kbd_error  <= 1'b0;
    end else begin
      r_tx_start  <= 1'b0;
      r_key_valid <= 1'b0;
      r_led_live  <= w_led_pins;
      // Timeout clock only runs once the command has left the transceiver.
      if (w_tick && !tx_busy && (r_ms != '1)) r_ms <= r_ms + 11'd1;
      if (init_req) begin
        r_state     <= RST_TX;
        r_retry     <= '0;
        r_kbd_error <= 1'b0;
        r_kbd_ready <= 1'b0;
      end else if (w_fail) begin
        if (r_retry >= RETRY_LAST) begin
          r_state     <= FAIL;
          r_kbd_error <= 1'b1;
          r_kbd_ready <= 1'b0;
        end else begin
          r_retry <= r_retry + 4'd1;
          r_state <= w_retry_to;
        end
      end else begin
        case (r_state)
          RST_TX: if (!tx_busy) begin
            r_tx_data  <= 8'hFF;
            r_tx_start <= 1'b1;
            r_ms       <= '0;
            r_state    <= RST_ACK;
          end
          RST_ACK: if (w_ack_ok) begin
            r_retry <= '0;
            r_ms    <= '0;
            r_state <= BAT_WAIT;
          end
          BAT_WAIT: if (w_bat_ok) begin
            r_retry <= '0;
            r_state <= LED_CMD_TX;
          end
          LED_CMD_TX: if (!tx_busy) begin
            r_tx_data  <= 8'hED;
            r_tx_start <= 1'b1;
            r_ms       <= '0;
            r_state    <= LED_CMD_ACK;
          end
          LED_CMD_ACK: if (w_ack_ok) begin
            r_retry <= '0;
            r_state <= LED_DAT_TX;
          end
          LED_DAT_TX: if (!tx_busy) begin
            r_led_shadow <= w_led_pins;
            r_tx_data    <= {5'b0, w_led_pins};
            r_tx_start   <= 1'b1;
            r_ms         <= '0;
            r_state      <= LED_DAT_ACK;
          end
          LED_DAT_ACK: if (w_ack_ok) begin
            r_retry     <= '0;
            r_kbd_ready <= 1'b1;
            r_state     <= READY;
          end
          READY: begin
            if (rx_valid && w_is_scan) begin
              r_key_byte  <= rx_byte;
              r_key_valid <= 1'b1;
            end
            if ((rx_valid && (rx_byte == 8'hAA)) || (r_led_live != r_led_shadow)) begin
              r_kbd_ready <= 1'b0;
              r_state     <= LED_CMD_TX;
            end
          end
          FAIL: ;
          default: r_state <= RST_TX;
        endcase
      end
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign key_byte  = r_key_byte;
  assign key_valid = r_key_valid;
  assign kbd_ready = r_kbd_ready;
  assign kbd_error = r_kbd_error;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: a scripted keyboard drives replies; transmitted bytes and
// filtered scancodes are checked against expected queues.
module tb_ps2_host_ctrl;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       init_req = 1'b0;
  logic       led_caps = 1'b1;
  logic       led_num = 1'b1;
  logic       led_scroll = 1'b1;
  logic       tx_busy = 1'b0;
  logic       tx_err = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_data;
  logic [7:0] key_byte;
  logic       tx_start;
  logic       key_valid;
  logic       kbd_ready;
  logic       kbd_error;
  logic [3:0] dbg_state;

  logic [W-1:0] exp_tx_q[$];
  logic [W-1:0] exp_key_q[$];
  int           tx_cyc[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           tx_cnt = 0;
  int           tx_pushed = 0;
  int           key_cnt = 0;
  int           cyc = 0;

  ps2_host_ctrl #(.CLK_FREQ(100000)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req),
    .led_caps(led_caps), .led_num(led_num), .led_scroll(led_scroll),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_err(tx_err),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
    .key_byte(key_byte), .key_valid(key_valid),
    .kbd_ready(kbd_ready), .kbd_error(kbd_error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard monitor: every transmitted byte and every key pulse must be expected
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start) begin
          tx_cnt++;
          tx_cyc.push_back(cyc);
          check("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
          if (exp_tx_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
        end
        if (key_valid) begin
          key_cnt++;
          check("key_expected", 32'(exp_key_q.size() != 0), 32'd1);
          if (exp_key_q.size() != 0) check("key_byte", 32'(key_byte), 32'(exp_key_q.pop_front()));
        end
      end
    end
  endtask

  // transceiver model: busy for a while after each transmit request
  task automatic busy_model();
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        tx_busy = 1'b1;
        repeat (20) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  endtask

  task automatic watchdog();
    #600000;
    n_fail++;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  endtask

  // driver tasks
  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    exp_tx_q.push_back(b);
    tx_pushed++;
  endtask

  task automatic wait_tx(input string tag, input int budget);
    int i;
    i = 0;
    while ((tx_cnt < tx_pushed) && (i < budget)) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(tx_cnt), 32'(tx_pushed));
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    tick(1);
    while (tx_busy && (i < 200)) begin
      @(negedge clk);
      i++;
    end
    tick($urandom_range(1, 8));
  endtask

  task automatic pulse_init();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  initial begin
    logic [7:0] scan_in [10];
    int         k0;
    int         idx;
    int         gap;

    fork
      monitor();
      busy_model();
      watchdog();
    join_none

    // reset values
    #1 rst_n = 1'b0;
    tick(3);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_byte", 32'(key_byte), 32'h00);
    check("rst_ready", 32'(kbd_ready), 32'd0);
    check("rst_error", 32'(kbd_error), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // power-up with a nominal keyboard
    push_tx(8'hFF);
    @(negedge clk) rst_n = 1'b1;
    wait_tx("pu_ff", 50);
    wait_idle();
    send_rx(8'hFA);
    push_tx(8'hED);
    send_rx(8'hAA);
    wait_tx("pu_ed", 50);
    wait_idle();
    push_tx(8'h07);
    send_rx(8'hFA);
    wait_tx("pu_led07", 50);
    wait_idle();
    send_rx(8'hFA);
    tick(3);
    check("pu_ready", 32'(kbd_ready), 32'd1);
    check("pu_error", 32'(kbd_error), 32'd0);
    check("pu_no_keys", 32'(key_cnt), 32'd0);

    // resend requested on the first ED
    push_tx(8'hFF);
    pulse_init();
    check("rs_ready_drop", 32'(kbd_ready), 32'd0);
    wait_tx("rs_ff", 50);
    wait_idle();
    send_rx(8'hFA);
    push_tx(8'hED);
    send_rx(8'hAA);
    wait_tx("rs_ed", 50);
    wait_idle();
    push_tx(8'hED);
    send_rx(8'hFE);
    wait_tx("rs_ed_again", 50);
    wait_idle();
    push_tx(8'h07);
    send_rx(8'hFA);
    wait_tx("rs_led07", 50);
    wait_idle();
    send_rx(8'hFA);
    tick(3);
    check("rs_ready", 32'(kbd_ready), 32'd1);

    // scancode filtering in READY
    scan_in = '{8'h1C, 8'hF0, 8'h1C, 8'hFA, 8'hE0, 8'h75, 8'h00, 8'hEE, 8'hFE, 8'hFF};
    exp_key_q.push_back(8'h1C);
    exp_key_q.push_back(8'hF0);
    exp_key_q.push_back(8'h1C);
    exp_key_q.push_back(8'hE0);
    exp_key_q.push_back(8'h75);
    k0 = key_cnt;
    for (int i = 0; i < 10; i++) begin
      send_rx(scan_in[i]);
      tick($urandom_range(1, 6));
    end
    tick(4);
    check("scan_count", 32'(key_cnt - k0), 32'd5);
    check("scan_q_empty", 32'(exp_key_q.size()), 32'd0);
    check("scan_ready", 32'(kbd_ready), 32'd1);

    // LED change caps 1->0
    push_tx(8'hED);
    @(negedge clk) led_caps = 1'b0;
    tick(3);
    check("led_ready_drop", 32'(kbd_ready), 32'd0);
    wait_tx("led_ed", 50);
    wait_idle();
    push_tx(8'h03);
    send_rx(8'hFA);
    wait_tx("led_03", 50);
    wait_idle();
    send_rx(8'hFA);
    tick(3);
    check("led_ready", 32'(kbd_ready), 32'd1);

    // spontaneous self-test pass in READY
    push_tx(8'hED);
    send_rx(8'hAA);
    check("aa_ready_drop", 32'(kbd_ready), 32'd0);
    wait_tx("aa_ed", 50);
    wait_idle();
    push_tx(8'h03);
    send_rx(8'hFA);
    wait_tx("aa_03", 50);
    wait_idle();
    send_rx(8'hFA);
    tick(3);
    check("aa_ready", 32'(kbd_ready), 32'd1);

    // silent keyboard: three FF attempts about 20 ms apart, then failure
    idx = tx_cyc.size();
    push_tx(8'hFF);
    push_tx(8'hFF);
    push_tx(8'hFF);
    pulse_init();
    wait_tx("sil_ff3", 8000);
    if (tx_cyc.size() >= idx + 3) begin
      for (int i = 0; i < 2; i++) begin
        gap = tx_cyc[idx + i + 1] - tx_cyc[idx + i];
        check("sil_gap", 32'((gap >= 1800) && (gap <= 2200)), 32'd1);
      end
    end
    tick(2500);
    check("sil_error", 32'(kbd_error), 32'd1);
    check("sil_ready", 32'(kbd_ready), 32'd0);
    check("sil_no_4th", 32'(tx_cnt), 32'(tx_pushed));
    push_tx(8'hFF);
    pulse_init();
    check("sil_err_clear", 32'(kbd_error), 32'd0);
    wait_tx("sil_ff_again", 50);

    // reset while waiting for the self-test result
    wait_idle();
    send_rx(8'hFA);
    tick(3);
    check("mid_bat_state", 32'(dbg_state), 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_tx_data", 32'(tx_data), 32'h00);
    check("mid_tx_start", 32'(tx_start), 32'd0);
    check("mid_key_byte", 32'(key_byte), 32'h00);
    check("mid_key_valid", 32'(key_valid), 32'd0);
    check("mid_ready", 32'(kbd_ready), 32'd0);
    check("mid_error", 32'(kbd_error), 32'd0);
    check("mid_state", 32'(dbg_state), 32'd0);
    tick(3);
    push_tx(8'hFF);
    @(negedge clk) rst_n = 1'b1;
    wait_tx("mid_ff_again", 100);

    // final report
    tick(5);
    check("end_tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
    check("end_key_q_empty", 32'(exp_key_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
